// File: rtl/cpu_pkg.sv
// Shared miniRV definitions: datapath width, NOP encoding, reset vector and
// the fetch-stage state encoding.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST     = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// PC register and next-PC selection. npc is also the sync ROM address, so the
// ROM output always belongs to pc one cycle later.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  fetch_state_e    state,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc
);

  // BOOT holds the PC so the ROM gets one cycle to read the reset vector;
  // stall is meaningless there, a redirect still applies.
  always_comb begin
    npc = pc + XLEN'(4);
    if (flush)
      npc = word_align(redirect_pc);
    else if (stall || state == S_BOOT)
      npc = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= npc;
  end

endmodule

// File: rtl/ifetch.sv
// miniRV instruction-fetch stage: PC/next-PC (pc_reg), BOOT/RUN sequencing and
// the IF/ID register. Optional counters enabled by defining IFETCH_PERF_EN.
module ifetch
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] irom_addr,
  input  logic [XLEN-1:0] irom_inst,
  output logic [XLEN-1:0] if_id_inst,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc4,
  output logic            if_id_valid
`ifdef IFETCH_PERF_EN
  ,
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] bubble_cnt
`endif
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, npc;
  logic            run, load, squash;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .npc         (npc)
  );

  assign irom_addr = npc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_BOOT;
    else        state <= state_nxt;
  end

  // Flush outranks stall; nothing enters IF/ID while booting.
  always_comb begin
    state_nxt = S_RUN;
    run       = (state == S_RUN);
    squash    = run && flush;
    load      = run && !flush && !stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_inst  <= NOP_INST;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (squash) begin
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
    end else if (load) begin
      if_id_inst  <= irom_inst;
      if_id_pc    <= pc;
      if_id_pc4   <= pc + XLEN'(4);
      if_id_valid <= 1'b1;
    end
  end

`ifdef IFETCH_PERF_EN
  logic valid_nxt, bubble_inc;

  always_comb begin
    valid_nxt = if_id_valid;
    if (squash)    valid_nxt = 1'b0;
    else if (load) valid_nxt = 1'b1;
    bubble_inc = run && (!valid_nxt || stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (load)       fetch_cnt  <= fetch_cnt + XLEN'(1);
      if (bubble_inc) bubble_cnt <= bubble_cnt + XLEN'(1);
    end
  end
`endif

endmodule
